// File: rtl/sa_output_writeback.sv
// Drain stage of the systolic array: shadows one finished tile, adds a per-column bias,
// shifts/saturates each element and writes the tile row-major into the output SRAM.
module sa_output_writeback #(
  parameter int TILE_DIM   = 2,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH,
  parameter int ADDR_WIDTH = 16,
  parameter int OUT_SHIFT  = 0,
  parameter int BIAS_BASE  = 0,
  parameter int OUT_BASE   = 0
) (
  input  logic                                   clk,
  input  logic                                   rstn,
  input  logic                                   start,
  input  logic [TILE_DIM*TILE_DIM*ACC_WIDTH-1:0] acc_in,
  input  logic [31:0]                            blk_row_idx,
  input  logic [31:0]                            blk_col_idx,
  input  logic [31:0]                            N,
  output logic                                   bias_cs,
  output logic [ADDR_WIDTH-1:0]                  bias_addr,
  input  logic [DATA_WIDTH-1:0]                  bias_rdata,
  output logic                                   out_cs,
  output logic                                   out_we,
  output logic [ADDR_WIDTH-1:0]                  out_addr,
  output logic [DATA_WIDTH-1:0]                  out_wdata,
  output logic                                   busy,
  output logic                                   done
);

  localparam int IDX_W = (TILE_DIM > 1) ? $clog2(TILE_DIM) : 1;
  localparam int CNT_W = $clog2(TILE_DIM + 1);

  localparam logic signed [ACC_WIDTH:0] SAT_MAX =
    {{(ACC_WIDTH + 2 - DATA_WIDTH){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] SAT_MIN =
    {{(ACC_WIDTH + 2 - DATA_WIDTH){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BIAS  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t                        state_r, state_s;
  logic [CNT_W-1:0]              cnt_r, cnt_s;
  logic [IDX_W-1:0]              elem_row_r, elem_row_s;
  logic [IDX_W-1:0]              elem_col_r, elem_col_s;
  logic [31:0]                   row_r, row_s;
  logic [31:0]                   col_r, col_s;
  logic [31:0]                   n_r, n_s;
  logic signed [ACC_WIDTH-1:0]   acc_r [TILE_DIM][TILE_DIM];
  logic signed [ACC_WIDTH-1:0]   acc_s [TILE_DIM][TILE_DIM];
  logic signed [DATA_WIDTH-1:0]  bias_r [TILE_DIM];
  logic signed [DATA_WIDTH-1:0]  bias_s [TILE_DIM];
  logic                          issue_wr_s;

  logic                          bias_cs_r, bias_cs_s;
  logic [ADDR_WIDTH-1:0]         bias_addr_r, bias_addr_s;
  logic                          out_cs_r, out_cs_s;
  logic                          out_we_r, out_we_s;
  logic [ADDR_WIDTH-1:0]         out_addr_r, out_addr_s;
  logic [DATA_WIDTH-1:0]         out_wdata_r, out_wdata_s;
  logic                          busy_r, busy_s;
  logic                          done_r, done_s;

  function automatic logic [ADDR_WIDTH-1:0] bias_address(input logic [31:0] col,
                                                         input logic [31:0] j);
    logic [31:0] a;
    a = 32'(BIAS_BASE) + col * 32'(TILE_DIM) + j;
    return a[ADDR_WIDTH-1:0];
  endfunction

  // Full-width address wraps silently into ADDR_WIDTH.
  function automatic logic [ADDR_WIDTH-1:0] out_address(input logic [31:0] row,
                                                        input logic [31:0] col,
                                                        input logic [31:0] n,
                                                        input logic [IDX_W-1:0] r,
                                                        input logic [IDX_W-1:0] c);
    logic [31:0] a;
    a = 32'(OUT_BASE) + (row * 32'(TILE_DIM) + 32'(r)) * n + col * 32'(TILE_DIM) + 32'(c);
    return a[ADDR_WIDTH-1:0];
  endfunction

  // One extra bit of headroom makes the bias add overflow-free before shift and clamp.
  function automatic logic [DATA_WIDTH-1:0] wb_value(input logic signed [ACC_WIDTH-1:0] acc,
                                                     input logic signed [DATA_WIDTH-1:0] bias);
    logic signed [ACC_WIDTH:0] sum_v;
    logic signed [ACC_WIDTH:0] shf_v;
    logic [DATA_WIDTH-1:0]     res_v;
    sum_v = {acc[ACC_WIDTH-1], acc} +
            {{(ACC_WIDTH + 1 - DATA_WIDTH){bias[DATA_WIDTH-1]}}, bias};
    shf_v = sum_v >>> OUT_SHIFT;
    if (shf_v > SAT_MAX) begin
      res_v = SAT_MAX[DATA_WIDTH-1:0];
    end else if (shf_v < SAT_MIN) begin
      res_v = SAT_MIN[DATA_WIDTH-1:0];
    end else begin
      res_v = shf_v[DATA_WIDTH-1:0];
    end
    return res_v;
  endfunction

  // Next-state and next-output logic for the drain sequence.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    elem_row_s  = elem_row_r;
    elem_col_s  = elem_col_r;
    row_s       = row_r;
    col_s       = col_r;
    n_s         = n_r;
    acc_s       = acc_r;
    bias_s      = bias_r;
    issue_wr_s  = 1'b0;
    bias_cs_s   = 1'b0;
    bias_addr_s = '0;
    done_s      = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (start) begin
          for (int r = 0; r < TILE_DIM; r++) begin
            for (int c = 0; c < TILE_DIM; c++) begin
              acc_s[r][c] = acc_in[(TILE_DIM*TILE_DIM - 1 - (r*TILE_DIM + c))*ACC_WIDTH +: ACC_WIDTH];
            end
          end
          row_s       = blk_row_idx;
          col_s       = blk_col_idx;
          n_s         = N;
          cnt_s       = '0;
          bias_cs_s   = 1'b1;
          bias_addr_s = bias_address(blk_col_idx, 32'd0);
          state_s     = ST_BIAS;
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_BIAS: begin
        // Read data for request j arrives while cnt_r == j+1.
        for (int j = 0; j < TILE_DIM; j++) begin
          if (cnt_r == CNT_W'(j + 1)) begin
            bias_s[j] = bias_rdata;
          end else begin
            bias_s[j] = bias_r[j];
          end
        end
        if (cnt_r == CNT_W'(TILE_DIM)) begin
          cnt_s      = '0;
          elem_row_s = '0;
          elem_col_s = '0;
          issue_wr_s = 1'b1;
          state_s    = ST_WRITE;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
          if (cnt_r < CNT_W'(TILE_DIM - 1)) begin
            bias_cs_s   = 1'b1;
            bias_addr_s = bias_address(col_r, 32'(cnt_r) + 32'd1);
          end else begin
            bias_cs_s   = 1'b0;
          end
        end
      end

      ST_WRITE: begin
        if ((elem_row_r == IDX_W'(TILE_DIM - 1)) && (elem_col_r == IDX_W'(TILE_DIM - 1))) begin
          done_s  = 1'b1;
          state_s = ST_DONE;
        end else begin
          if (elem_col_r == IDX_W'(TILE_DIM - 1)) begin
            elem_col_s = '0;
            elem_row_s = elem_row_r + IDX_W'(1);
          end else begin
            elem_col_s = elem_col_r + IDX_W'(1);
          end
          issue_wr_s = 1'b1;
        end
      end

      ST_DONE: begin
        state_s = ST_IDLE;
      end

      default: begin
        state_s = ST_IDLE;
      end
    endcase

    if (issue_wr_s) begin
      out_cs_s    = 1'b1;
      out_we_s    = 1'b1;
      out_addr_s  = out_address(row_s, col_s, n_s, elem_row_s, elem_col_s);
      out_wdata_s = wb_value(acc_s[elem_row_s][elem_col_s], bias_s[elem_col_s]);
    end else begin
      out_cs_s    = 1'b0;
      out_we_s    = 1'b0;
      out_addr_s  = '0;
      out_wdata_s = '0;
    end

    busy_s = (state_s != ST_IDLE);
  end

  // State, shadow and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r     <= ST_IDLE;
      cnt_r       <= '0;
      elem_row_r  <= '0;
      elem_col_r  <= '0;
      row_r       <= '0;
      col_r       <= '0;
      n_r         <= '0;
      acc_r       <= '{default: '0};
      bias_r      <= '{default: '0};
      bias_cs_r   <= 1'b0;
      bias_addr_r <= '0;
      out_cs_r    <= 1'b0;
      out_we_r    <= 1'b0;
      out_addr_r  <= '0;
      out_wdata_r <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      elem_row_r  <= elem_row_s;
      elem_col_r  <= elem_col_s;
      row_r       <= row_s;
      col_r       <= col_s;
      n_r         <= n_s;
      acc_r       <= acc_s;
      bias_r      <= bias_s;
      bias_cs_r   <= bias_cs_s;
      bias_addr_r <= bias_addr_s;
      out_cs_r    <= out_cs_s;
      out_we_r    <= out_we_s;
      out_addr_r  <= out_addr_s;
      out_wdata_r <= out_wdata_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
    end
  end

  assign bias_cs   = bias_cs_r;
  assign bias_addr = bias_addr_r;
  assign out_cs    = out_cs_r;
  assign out_we    = out_we_r;
  assign out_addr  = out_addr_r;
  assign out_wdata = out_wdata_r;
  assign busy      = busy_r;
  assign done      = done_r;

endmodule

// File: tb/tb_sa_output_writeback.sv
// Randomized and directed bench for sa_output_writeback: two instances (shift 0 and 2)
// share stimulus; expected timeline and writes come from a plain-arithmetic tile model.
module tb_sa_output_writeback;

  logic        clk = 1'b0;
  logic        rstn, start;
  logic [63:0] acc_in;
  logic [31:0] blk_row_idx, blk_col_idx, n_cols;
  logic [7:0]  bias_rdata;

  logic        bias_cs0, out_cs0, out_we0, busy0, done0;
  logic [15:0] bias_addr0, out_addr0;
  logic [7:0]  out_wdata0;
  logic        bias_cs1, out_cs1, out_we1, busy1, done1;
  logic [15:0] bias_addr1, out_addr1;
  logic [7:0]  out_wdata1;

  logic [7:0]  bias_mem [256];
  int          tile_acc [4];
  int          tile_bias [2];
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clk = ~clk;

  sa_output_writeback #(.OUT_SHIFT(0)) dut0 (
    .clk(clk), .rstn(rstn), .start(start), .acc_in(acc_in),
    .blk_row_idx(blk_row_idx), .blk_col_idx(blk_col_idx), .N(n_cols),
    .bias_cs(bias_cs0), .bias_addr(bias_addr0), .bias_rdata(bias_rdata),
    .out_cs(out_cs0), .out_we(out_we0), .out_addr(out_addr0), .out_wdata(out_wdata0),
    .busy(busy0), .done(done0));

  sa_output_writeback #(.OUT_SHIFT(2)) dut1 (
    .clk(clk), .rstn(rstn), .start(start), .acc_in(acc_in),
    .blk_row_idx(blk_row_idx), .blk_col_idx(blk_col_idx), .N(n_cols),
    .bias_cs(bias_cs1), .bias_addr(bias_addr1), .bias_rdata(bias_rdata),
    .out_cs(out_cs1), .out_we(out_we1), .out_addr(out_addr1), .out_wdata(out_wdata1),
    .busy(busy1), .done(done1));

  // Bias SRAM: one-cycle read latency, garbage when not selected.
  always @(posedge clk) begin
    bias_rdata <= bias_cs0 ? bias_mem[bias_addr0[7:0]] : 8'($urandom);
  end

  task automatic chk(input string tag, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int exp_data(input int acc, input int bias, input int sh);
    int v;
    v = (acc + bias) >>> sh;
    if (v > 127) v = 127;
    else if (v < -128) v = -128;
    return v;
  endfunction

  function automatic int exp_out_addr(input int row, input int col, input int nn,
                                      input int r, input int c);
    return ((row * 2 + r) * nn + col * 2 + c) & 32'hFFFF;
  endfunction

  task automatic set_tile(input int a0, input int a1, input int a2, input int a3,
                          input int b0, input int b1);
    tile_acc[0] = a0; tile_acc[1] = a1; tile_acc[2] = a2; tile_acc[3] = a3;
    tile_bias[0] = b0; tile_bias[1] = b1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".bias_cs"},   int'(bias_cs0),   0);
    chk({tag, ".bias_addr"}, int'(bias_addr0), 0);
    chk({tag, ".out_cs"},    int'(out_cs0),    0);
    chk({tag, ".out_we"},    int'(out_we0),    0);
    chk({tag, ".out_addr"},  int'(out_addr0),  0);
    chk({tag, ".out_wdata"}, int'(out_wdata0), 0);
    chk({tag, ".busy"},      int'(busy0),      0);
    chk({tag, ".done"},      int'(done0),      0);
    chk({tag, ".out_cs1"},   int'(out_cs1),    0);
    chk({tag, ".busy1"},     int'(busy1),      0);
  endtask

  // Called at a falling edge; start is sampled at the next rising edge (cycle 0).
  task automatic launch(input int row, input int col, input int nn);
    for (int j = 0; j < 2; j++) bias_mem[(col * 2 + j) & 255] = 8'(tile_bias[j]);
    blk_row_idx = 32'(row);
    blk_col_idx = 32'(col);
    n_cols      = 32'(nn);
    for (int e = 0; e < 4; e++) acc_in[(3 - e) * 16 +: 16] = 16'(tile_acc[e]);
    start = 1'b1;
    @(posedge clk);
    #1;
    start       = 1'b0;
    acc_in      = {$urandom, $urandom};
    blk_row_idx = $urandom;
    blk_col_idx = $urandom;
    n_cols      = $urandom;
  endtask

  task automatic run_tile(input string nm, input int row, input int col, input int nn,
                          input bit poke);
    int e, r, c;
    launch(row, col, nn);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      chk({nm, ".busy"},    int'(busy0),    (k <= 8) ? 1 : 0);
      chk({nm, ".done"},    int'(done0),    (k == 8) ? 1 : 0);
      chk({nm, ".done1"},   int'(done1),    (k == 8) ? 1 : 0);
      chk({nm, ".bias_cs"}, int'(bias_cs0), (k == 1 || k == 2) ? 1 : 0);
      if (k == 1 || k == 2)
        chk({nm, ".bias_addr"}, int'(bias_addr0), (col * 2 + k - 1) & 32'hFFFF);
      chk({nm, ".cs_excl"}, int'(bias_cs0 & out_cs0), 0);
      chk({nm, ".out_cs"},  int'(out_cs0), (k >= 4 && k <= 7) ? 1 : 0);
      chk({nm, ".out_cs1"}, int'(out_cs1), (k >= 4 && k <= 7) ? 1 : 0);
      if (k >= 4 && k <= 7) begin
        e = k - 4; r = e / 2; c = e % 2;
        chk({nm, ".out_we"},    int'(out_we0),   1);
        chk({nm, ".out_addr"},  int'(out_addr0), exp_out_addr(row, col, nn, r, c));
        chk({nm, ".wdata"},     int'($signed(out_wdata0)), exp_data(tile_acc[e], tile_bias[c], 0));
        chk({nm, ".out_addr1"}, int'(out_addr1), exp_out_addr(row, col, nn, r, c));
        chk({nm, ".wdata_sh2"}, int'($signed(out_wdata1)), exp_data(tile_acc[e], tile_bias[c], 2));
      end
      start = (poke && (k == 3 || k == 8)) ? 1'b1 : 1'b0;
    end
    start = 1'b0;
  endtask

  task automatic run_abort();
    set_tile(11, 22, 33, 44, 1, 2);
    launch(0, 0, 4);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k >= 4) begin
        chk("abort.out_cs",   int'(out_cs0),   1);
        chk("abort.out_addr", int'(out_addr0), k - 4);
      end
    end
    rstn = 1'b0;
    @(negedge clk);
    chk_idle("abort");
    rstn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk_idle("post_abort");
    end
  endtask

  function automatic int rnd_acc();
    if ($urandom_range(0, 1) == 0) return int'($signed(16'($urandom)));
    return int'($urandom_range(0, 600)) - 300;
  endfunction

  initial begin
    rstn = 1'b0; start = 1'b0; acc_in = '0;
    blk_row_idx = '0; blk_col_idx = '0; n_cols = '0;
    for (int i = 0; i < 256; i++) bias_mem[i] = 8'($urandom);
    repeat (3) @(negedge clk);
    chk_idle("reset");
    rstn = 1'b1;
    @(negedge clk);

    set_tile(1, 2, 3, 4, 0, 0);
    run_tile("basic", 1, 2, 6, 1'b0);
    set_tile(10, 10, 10, 10, 5, -3);
    run_tile("bias_col", 0, 1, 4, 1'b0);
    set_tile(200, -300, -20, 127, 10, 0);
    run_tile("sat_a", 3, 0, 8, 1'b0);
    set_tile(-128, 5, 90, -7, -1, 1);
    run_tile("sat_b", 0, 3, 8, 1'b0);
    set_tile(-9, 1023, 4, -4, 0, 1);
    run_tile("shift", 2, 1, 10, 1'b0);
    set_tile(7, -7, 100, -100, 3, -3);
    run_tile("ignore_start", 1, 1, 5, 1'b1);
    set_tile(50, 60, 70, 80, 0, 0);
    run_tile("back2back", 1, 1, 5, 1'b0);

    run_abort();
    set_tile(1, 2, 3, 4, 0, 0);
    run_tile("after_abort", 1, 2, 6, 1'b0);

    for (int t = 0; t < 24; t++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      set_tile(rnd_acc(), rnd_acc(), rnd_acc(), rnd_acc(),
               int'($signed(8'($urandom))), int'($signed(8'($urandom))));
      run_tile("rand", int'($urandom_range(0, 20)), int'($urandom_range(0, 100)),
               ($urandom_range(0, 1) == 0) ? int'($urandom_range(2, 50))
                                           : int'($urandom_range(30000, 65535)),
               1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sa_output_writeback.md
Name: sa_output_writeback

Overview:
- Downstream drain stage of the systolic array.
- Captures one finished TILE_DIM x TILE_DIM tile of signed accumulators and adds a per-output-column bias read from the bias SRAM.
- Arithmetic-shifts and saturates each result to DATA_WIDTH, then writes the tile row-major into the output SRAM at the tile's position in the M x N output matrix.
- Raises a one-cycle done so the controller can advance to the next tile.

Parameters:
- TILE_DIM, 2, tile edge; the array produces TILE_DIM*TILE_DIM accumulators.
- DATA_WIDTH, 8, width of bias words and output words (signed two's complement).
- ACC_WIDTH, 2*DATA_WIDTH, width of each accumulator (signed).
- ADDR_WIDTH, 16, SRAM word-address width.
- OUT_SHIFT, 0, arithmetic right shift applied after bias add (0..ACC_WIDTH-1).
- BIAS_BASE, 0, word address of bias[0] in the bias SRAM.
- OUT_BASE, 0, word address of output element (0,0) in the output SRAM.

Ports:
- clk  input  1  clock.
- rstn  input  1  synchronous, active-low reset.
- start  input  1  one-cycle pulse: acc_in holds a finished tile; sampled only in IDLE.
- acc_in  input  TILE_DIM*TILE_DIM*ACC_WIDTH  tile accumulators. Element (r,c) is at big-endian slice index r*TILE_DIM+c, MSB-first like the array output bus.
- blk_row_idx  input  32  tile row index; sampled on accepted start.
- blk_col_idx  input  32  tile column index; sampled on accepted start.
- N  input  32  output matrix column count in elements; sampled on accepted start.
- bias_cs  output  1  bias SRAM chip select (read only).
- bias_addr  output  ADDR_WIDTH  bias read address.
- bias_rdata  input  DATA_WIDTH  bias read data, valid exactly 1 cycle after bias_cs.
- out_cs  output  1  output SRAM chip select.
- out_we  output  1  output SRAM write enable.
- out_addr  output  ADDR_WIDTH  output write address.
- out_wdata  output  DATA_WIDTH  output write data.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse when the tile is fully written.

Behaviour:
- Reset (rstn=0 at a clk edge): state=IDLE, all outputs 0, counters 0.
  - Reset mid-operation abandons the tile immediately; no further SRAM accesses occur.
- States: IDLE -> BIAS -> WRITE -> DONE -> IDLE.
- IDLE
  - On start=1: register acc_in, blk_row_idx, blk_col_idx and N, then go to BIAS.
  - start is ignored in all other states; it is neither queued nor errored.
- BIAS (TILE_DIM+1 cycles)
  - Cycle j (0..TILE_DIM-1): bias_cs=1, bias_addr=BIAS_BASE + blk_col_idx*TILE_DIM + j.
  - Cycle j+1: latch bias_rdata into bias_reg[j].
  - Last cycle: bias_cs=0, capture the final word, go to WRITE.
- WRITE (TILE_DIM*TILE_DIM cycles, one write per cycle, element e = r*TILE_DIM+c)
  - out_cs=1, out_we=1.
  - out_addr = OUT_BASE + (blk_row_idx*TILE_DIM + r)*N + blk_col_idx*TILE_DIM + c.
  - Address is computed in 32 bits and truncated to ADDR_WIDTH; wrap is silent.
  - out_wdata = sat( (acc[e] + sext(bias_reg[c])) >>> OUT_SHIFT ).
    - The sum is computed at ACC_WIDTH+1 bits, so it never overflows.
    - sat clamps to [-(2^(DATA_WIDTH-1)), 2^(DATA_WIDTH-1)-1].
  - After the last element, go to DONE.
- DONE (1 cycle): done=1, all SRAM strobes 0, then IDLE.
  - start is accepted again in the cycle after DONE.
- Latency for TILE_DIM=2 (start sampled at edge 0):
  - busy=1 for cycles 1..8.
  - Bias reads in cycles 1-2; writes in cycles 4-7.
  - done in cycle 8.
- All outputs are registered. bias_cs and out_cs are never high in the same cycle.
- acc_in may change freely after the start cycle because it is shadowed.

Test Plan:
- Reset while in WRITE after 2 writes -> outputs 0, busy=0, no further out_cs. A new start then produces a complete 4-write tile.
- TILE_DIM=2, N=6, blk_row_idx=1, blk_col_idx=2, bias all 0, acc={1,2,3,4}:
  - writes addr 16,17,22,23 with data 1,2,3,4;
  - bias_addr 4,5 in cycles 1-2; done at cycle 8.
- Bias per column: bias_rdata 5 then -3, acc={10,10,10,10} -> data 15,7,15,7.
- Saturation, DATA_WIDTH=8: acc=200 bias=10 -> 127; acc=-300 bias=0 -> -128; acc=-128 bias=-1 -> -128; acc=127 bias=0 -> 127.
- OUT_SHIFT=2: acc=-9 bias=0 -> -3 (arithmetic shift floors); acc=1023 bias=1 -> 127 (saturated after shift).
- start pulsed in cycles 3 and 8 during the busy period -> ignored: exactly one done and 4 writes. start at cycle 9 begins a second tile, with done at cycle 17.
